// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock.
// The cipher key is latched on an accepted start and driven to key_expand.
// The round keys come back combinationally and are applied in rounds 1..10.
module aes_encrypt_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key_in,
    output logic [127:0] aes_key,
    input  logic [127:0] key1,
    input  logic [127:0] key2,
    input  logic [127:0] key3,
    input  logic [127:0] key4,
    input  logic [127:0] key5,
    input  logic [127:0] key6,
    input  logic [127:0] key7,
    input  logic [127:0] key8,
    input  logic [127:0] key9,
    input  logic [127:0] key10,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // FIPS-197 S-box; element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t         fsm_q;
    logic [3:0]   round_q;
    logic [127:0] state_q;
    logic [127:0] aes_key_q;
    logic [127:0] ct_q;
    logic         busy_q;
    logic         done_q;

    logic [127:0] rk_d;
    logic [127:0] sr_d;
    logic [127:0] state_d;
    logic [127:0] ct_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return o;
    endfunction

    // Byte n lives at bits [127-8n -: 8]; byte (row r, column c) is n = 4c + r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Round-key select and the combinational round datapath.
    always_comb begin
        rk_d = '0;
        case (round_q)
            4'd1:    rk_d = key1;
            4'd2:    rk_d = key2;
            4'd3:    rk_d = key3;
            4'd4:    rk_d = key4;
            4'd5:    rk_d = key5;
            4'd6:    rk_d = key6;
            4'd7:    rk_d = key7;
            4'd8:    rk_d = key8;
            4'd9:    rk_d = key9;
            4'd10:   rk_d = key10;
            default: rk_d = '0;
        endcase
        sr_d    = shift_rows(sub_bytes(state_q));
        state_d = mix_columns(sr_d) ^ rk_d;
        ct_d    = sr_d ^ rk_d;
    end

    // Control FSM with the round state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q     <= IDLE;
            round_q   <= 4'd0;
            state_q   <= '0;
            aes_key_q <= '0;
            ct_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        // Initial AddRoundKey uses key_in directly: aes_key is not yet loaded.
                        state_q   <= plaintext ^ key_in;
                        aes_key_q <= key_in;
                        round_q   <= 4'd1;
                        busy_q    <= 1'b1;
                        fsm_q     <= RUN;
                    end
                end
                RUN: begin
                    if (round_q == LAST_ROUND) begin
                        ct_q    <= ct_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        round_q <= 4'd0;
                        fsm_q   <= IDLE;
                    end else begin
                        state_q <= state_d;
                        round_q <= round_q + 4'd1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign aes_key    = aes_key_q;
    assign ciphertext = ct_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
- Iterative AES-128 encryption core, one round per clock. Sits directly downstream of key_expand and consumes its round keys.
- Latches the cipher key and drives it to key_expand. Applies key_expand's combinational round keys key1..key10 in rounds 1..10.
- Produces one 128-bit ciphertext per start, with a done pulse.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128; other values unsupported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- plaintext  input  128  block to encrypt; sampled on the accepted start
- key_in  input  128  cipher key; sampled on the accepted start
- aes_key  output  128  registered cipher key, wired to key_expand.aes_key
- key1..key10  input  128 each  round keys from key_expand
- busy  output  1  high while rounds are in progress
- done  output  1  one-cycle pulse when ciphertext is valid
- ciphertext  output  128  result; holds until the next done or reset

Behaviour:
- Byte order (FIPS-197): byte 0 = bits [127:120]; state is column-major, so bytes 0..3 are column 0.
- Reset (synchronous, active-high):
  - FSM goes to IDLE; round counter = 0; internal state = 0.
  - aes_key = 0, ciphertext = 0, busy = 0, done = 0.
  - Reset overrides start in the same cycle.
  - Reset mid-operation abandons the block; no done is issued.
- FSM states: IDLE, RUN.
- IDLE with start=1 at edge E0:
  - state <= plaintext XOR key_in (initial AddRoundKey uses key_in directly, not aes_key).
  - aes_key <= key_in.
  - round <= 1; busy <= 1; go to RUN.
- RUN, round r in 1..9, at each edge:
  - state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key_r).
  - round <= r+1.
- RUN, round 10, at edge E10:
  - ciphertext <= AddRoundKey(ShiftRows(SubBytes(state)), key10). No MixColumns.
  - done <= 1; busy <= 0; round <= 0; go to IDLE.
- Round-key timing: key_expand is combinational from aes_key, so key_r is valid from the cycle after E0. aes_key is stable for the whole operation by construction.
- Latency: start sampled at E0; done high for the cycle after E10 (10 cycles); ciphertext valid on the same cycle.
- done is 1 for exactly one cycle per operation, then 0.
- Throughput: one block per 11 cycles. start may be reasserted in the cycle done is high; it is accepted because the FSM is in IDLE.
- start while RUN is ignored. plaintext/key_in changes during RUN have no effect.
- aes_key keeps the last key after completion; changes only on an accepted start or reset.
- SubBytes: 16 parallel combinational FIPS-197 S-box lookups. ShiftRows: row i rotated left by i bytes.
- MixColumns:
  - Each column is multiplied over GF(2^8) by the matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02].
  - xtime(b) = (b<<1) XOR (b[7] ? 8'h1b : 0).
- All datapath registers are 128 bits wide; no truncation or overflow cases exist.
- Round counter is 4 bits and never exceeds 10.

Test Plan:
- FIPS-197 App. B: key_in=2b7e151628aed2a6abf7158809cf4f3c, plaintext=3243f6a8885a308d313198a2e0370734, start 1 cycle -> done exactly 10 cycles after the start edge; ciphertext=3925841d02dc09fbdc118597196a0b32; aes_key=key_in.
- FIPS-197 App. C.1: key_in=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff -> ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a; busy high for exactly 10 cycles.
- Start ignored while busy: run the C.1 vector, pulse start with different plaintext/key_in at round 5 -> C.1 ciphertext unchanged; only one done pulse.
- Back-to-back: assert start with the App. B inputs in the cycle done is high for the C.1 run -> second done exactly 10 cycles later with 3925841d02dc09fbdc118597196a0b32; the first ciphertext holds during the second run.
- Reset mid-op: assert reset at round 4 of the C.1 run -> next cycle busy=0, done=0, ciphertext=0, aes_key=0; no done afterwards. A fresh start then yields the correct result.
- Reset priority: reset and start high in the same cycle -> stays IDLE, busy=0; done never asserts.
